matrix_loader: RTL

- Upstream stage of the input-matrix store in the PCA/SVD memory unit.
- Accepts a stream of 32-bit matrix elements on a valid/ready handshake, in row-major order, and assembles them into a 4x4 matrix.
- Presents the full matrix as one flat parallel bus with a matrix_valid qualifier.
- Holds the matrix stable until the consumer acknowledges it, and checks frame alignment with an end-of-matrix marker.

---
 rtl/matrix_loader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/matrix_loader.sv
// matrix_loader: assembles a row-major stream of 16 elements into a 4x4
// matrix presented on a flat parallel bus, held until acknowledged.
// Elements collect in a fill buffer; mat_out (front buffer) is updated
// atomically on a correctly framed completion only.
// Optional: define MATRIX_LOADER_DBUF_EN for double buffering (the next
// matrix fills while the current one is held).
module matrix_loader #(
  parameter int DATA_W = 32,
  parameter int N      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [N*N*DATA_W-1:0]   mat_out,
  output logic                    matrix_valid,
  input  logic                    matrix_ack,
  output logic                    frame_err,
  input  logic                    clr_err
);

  localparam int         ELEMS    = N * N;
  localparam logic [3:0] LAST_IDX = 4'(ELEMS - 1);

  // Only the 4x4 geometry is supported; refuse to elaborate otherwise.
  if (N != 4) begin : g_bad_n
    $error("matrix_loader: N must be 4");
  end

  typedef enum logic {LOAD = 1'b0, HOLD = 1'b1} state_t;

  state_t                    state_reg, state_next;
  logic [3:0]                idx_reg, idx_next;
  logic                      ready_reg, ready_next;
  logic                      valid_reg, valid_next;
  logic                      err_reg, err_next;
  logic [DATA_W-1:0]         fill_reg [ELEMS];
  logic [ELEMS*DATA_W-1:0]   mat_reg;
  logic [ELEMS*DATA_W-1:0]   fill_flat;
  logic [ELEMS*DATA_W-1:0]   direct_flat;
  logic                      accept, last_slot, bad_frame, complete, ack;
  logic                      fill_we, load_direct, load_fill;
`ifdef MATRIX_LOADER_DBUF_EN
  logic                      pending_reg, pending_next;
`endif

  // Flatten the fill buffer so it can be copied to mat_out in one edge.
  for (genvar gi = 0; gi < ELEMS; gi++) begin : g_flat
    assign fill_flat[gi*DATA_W +: DATA_W] = fill_reg[gi];
  end

  // Completion copies the 15 buffered elements plus the element on the bus.
  assign direct_flat = {in_data, fill_flat[(ELEMS-1)*DATA_W-1:0]};

  assign accept    = in_valid & ready_reg;
  assign last_slot = (idx_reg == LAST_IDX);
  assign bad_frame = accept & (in_last != last_slot);
  assign complete  = accept & in_last & last_slot;
  assign ack       = matrix_ack & valid_reg;

  assign in_ready     = ready_reg;
  assign mat_out      = mat_reg;
  assign matrix_valid = valid_reg;
  assign frame_err    = err_reg;

  // Next-state and control: indexing, framing check, LOAD/HOLD handshake.
  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    ready_next  = ready_reg;
    valid_next  = valid_reg;
    err_next    = bad_frame ? 1'b1 : (clr_err ? 1'b0 : err_reg);
    fill_we     = 1'b0;
    load_direct = 1'b0;
    load_fill   = 1'b0;
`ifdef MATRIX_LOADER_DBUF_EN
    pending_next = pending_reg;
`endif

    // A misframed element is dropped and the partial matrix abandoned.
    if (accept) begin
      if (bad_frame) begin
        idx_next = '0;
      end else begin
        fill_we  = 1'b1;
        idx_next = idx_reg + 4'd1;
      end
    end

    case (state_reg)
      LOAD: begin
        ready_next = 1'b1;
        if (complete) begin
          state_next  = HOLD;
          valid_next  = 1'b1;
          load_direct = 1'b1;
`ifndef MATRIX_LOADER_DBUF_EN
          ready_next  = 1'b0;
`endif
        end
      end
      HOLD: begin
`ifdef MATRIX_LOADER_DBUF_EN
        if (pending_reg) begin
          // Back buffer full: wait for the consumer, then swap it in.
          ready_next = 1'b0;
          if (ack) begin
            load_fill    = 1'b1;
            pending_next = 1'b0;
            ready_next   = 1'b1;
          end
        end else begin
          ready_next = 1'b1;
          if (complete && ack) begin
            load_direct = 1'b1;
          end else if (complete) begin
            pending_next = 1'b1;
            ready_next   = 1'b0;
          end else if (ack) begin
            state_next = LOAD;
            valid_next = 1'b0;
          end
        end
`else
        ready_next = 1'b0;
        if (ack) begin
          state_next = LOAD;
          valid_next = 1'b0;
          ready_next = 1'b1;
        end
`endif
      end
      default: state_next = LOAD;
    endcase
  end

  // State, buffers and flags; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= LOAD;
      idx_reg   <= '0;
      ready_reg <= 1'b0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      mat_reg   <= '0;
      for (int i = 0; i < ELEMS; i++) fill_reg[i] <= '0;
`ifdef MATRIX_LOADER_DBUF_EN
      pending_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      ready_reg <= ready_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
      if (fill_we) fill_reg[idx_reg] <= in_data;
      if (load_direct)    mat_reg <= direct_flat;
      else if (load_fill) mat_reg <= fill_flat;
`ifdef MATRIX_LOADER_DBUF_EN
      pending_reg <= pending_next;
`endif
    end
  end

endmodule
